add8_seq_ctrl: RTL and testbench

- Multi-precision add/subtract sequencer. Instantiates one Add8 and reuses it over NBYTES cycles, one byte per cycle, least-significant byte first.
- A registered carry links successive bytes.
- Provides a start/busy/done handshake so wide operands can be added without a wide adder. Sits between control logic and Add8.

---
 rtl/add8_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_add8_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add8_seq_ctrl.sv
// add8_seq_ctrl: byte-serial add/subtract sequencer built around one 8-bit adder.
// A W-bit operation (W = 8*NBYTES) is walked LSB byte first, one byte per clock,
// with a registered carry linking the steps.
// Optional build macro ADD8_SEQ_OVF_EN: adds output ovf, the signed overflow
// of the W-bit result, captured from the MSB byte step.

// Plain 8-bit adder with carry in/out; the sequencer reuses one instance per byte.
module add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    logic [8:0] sum;

    // Full 9-bit sum so the carry out falls out of the top bit.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b} + {8'b0, cin};
    end

    assign s    = sum[7:0];
    assign cout = sum[8];

endmodule

// state | meaning
// IDLE  | waiting for start; S/cout hold the last result
// RUN   | one byte per clock through add8, LSB first; busy=1
// DONE  | single cycle with done=1; start here chains the next operation
module add8_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [8*NBYTES-1:0]   A,
    input  logic [8*NBYTES-1:0]   B,
    output logic [8*NBYTES-1:0]   S,
    output logic                  cout,
`ifdef ADD8_SEQ_OVF_EN
    output logic                  ovf,
`endif
    output logic                  busy,
    output logic                  done
);

    localparam int W  = 8 * NBYTES;
    // Keep the index at least one bit wide so NBYTES=1 still elaborates.
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_lat;
    logic [W-1:0]  b_lat;
    logic          sub_lat;
    logic          carry_reg;

    logic [7:0]    a_byte;
    logic [7:0]    b_byte;
    logic [7:0]    b_eff;
    logic [7:0]    s_byte;
    logic          c_byte;

    // Pick the operand bytes addressed by the current step index.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == IW'(i)) begin
                a_byte = a_lat[8*i +: 8];
                b_byte = b_lat[8*i +: 8];
            end
        end
    end

    // Subtraction is A + ~B + 1; the +1 comes from carry_reg being preset at start.
    assign b_eff = sub_lat ? ~b_byte : b_byte;

    add8 u_add8 (
        .a    (a_byte),
        .b    (b_eff),
        .cin  (carry_reg),
        .s    (s_byte),
        .cout (c_byte)
    );

    // Sequencer: accepts start in IDLE/DONE, walks the bytes in RUN, pulses done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            a_lat     <= '0;
            b_lat     <= '0;
            sub_lat   <= 1'b0;
            carry_reg <= 1'b0;
            S         <= '0;
            cout      <= 1'b0;
`ifdef ADD8_SEQ_OVF_EN
            ovf       <= 1'b0;
`endif
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_lat     <= A;
                        b_lat     <= B;
                        sub_lat   <= sub;
                        carry_reg <= sub ? 1'b1 : cin;
                        idx       <= '0;
`ifdef ADD8_SEQ_OVF_EN
                        ovf       <= 1'b0;
`endif
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx == IW'(i)) begin
                            S[8*i +: 8] <= s_byte;
                        end
                    end
                    carry_reg <= c_byte;
                    if (idx == IW'(NBYTES - 1)) begin
                        cout  <= c_byte;
`ifdef ADD8_SEQ_OVF_EN
                        // Carry into the MSB is recovered from its sum bit.
                        ovf   <= (a_byte[7] ^ b_eff[7] ^ s_byte[7]) ^ c_byte;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add8_seq_ctrl.sv
// Scoreboard bench for add8_seq_ctrl (NBYTES=4): directed cases plus random
// operations; expected results come from plain wide arithmetic.
module tb_add8_seq_ctrl;

    localparam int N = 4;
    localparam int W = 8 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] S;
    logic         cout;
    logic         busy;
    logic         done;
`ifdef ADD8_SEQ_OVF_EN
    logic         ovf;
`endif

    add8_seq_ctrl #(.NBYTES(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .A     (A),
        .B     (B),
        .S     (S),
        .cout  (cout),
`ifdef ADD8_SEQ_OVF_EN
        .ovf   (ovf),
`endif
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference: exact wide arithmetic plus signed range check.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic m_sub, input logic m_cin);
        exp_t       e;
        logic [W:0] full;
        longint     sa;
        longint     sbv;
        longint     sr;
        longint     smax;
        longint     smin;
        if (m_sub) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else       full = {1'b0, a} + {1'b0, b} + (W+1)'(m_cin);
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        sr   = m_sub ? (sa - sbv) : (sa + sbv + longint'(m_cin));
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        e.s    = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (sr > smax) || (sr < smin);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                check("busy_with_done", 64'(busy), 64'(0));
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1, expected no pending result");
                end else begin
                    e = sb_q.pop_front();
                    check("S", 64'(S), 64'(e.s));
                    check("cout", 64'(cout), 64'(e.cout));
`ifdef ADD8_SEQ_OVF_EN
                    check("ovf", 64'(ovf), 64'(e.ovf));
`endif
                end
            end
        end
    end

    // Drive a start pulse (call just after a negedge); optionally expect a result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic m_sub, input logic m_cin, input bit expect_result);
        A     = a;
        B     = b;
        sub   = m_sub;
        cin   = m_cin;
        start = 1'b1;
        if (expect_result) sb_q.push_back(model(a, b, m_sub, m_cin));
    endtask

    // Count negedges until done (0 = timed out); drops start after the first edge.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 4 * N + 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic m_sub, input logic m_cin);
        int cyc;
        int bc;
        @(negedge clk);
        issue(a, b, m_sub, m_cin, 1'b1);
        wait_done(cyc, bc);
        check("done_latency", 64'(cyc), 64'(N + 1));
        check("busy_cycles", 64'(bc), 64'(N));
    endtask

    initial begin
        int cyc;
        int bc;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_S", 64'(S), 64'(0));
        check("reset_cout", 64'(cout), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
        run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check("S_held_idle", 64'(S), 64'(32'h0000_0002));

        // start re-pulsed mid-RUN must be ignored
        @(negedge clk);
        issue(32'h1, 32'h1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        issue(32'h10, 32'h10, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bc);
        check("repulse_latency", 64'(cyc), 64'(N + 1 - 3));

        // start high in the DONE cycle chains the next operation
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
        wait_done(cyc, bc);
        check("chain_latency", 64'(cyc), 64'(N + 1));
        check("chain_busy", 64'(bc), 64'(N));
        repeat (3) @(negedge clk);
        check("single_done_S", 64'(S), 64'(32'h2345_6789));

        // reset on the second RUN cycle aborts the operation
        @(negedge clk);
        issue(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_S", 64'(S), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_cout", 64'(cout), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        repeat (N + 2) @(negedge clk);
        run_op(32'h3, 32'h4, 1'b0, 1'b0);

        // reset and start together: start is dropped
        @(negedge clk);
        rst = 1'b1;
        issue(32'h5, 32'h5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 64'(busy), 64'(0));
        @(negedge clk);
        check("rst_start_busy2", 64'(busy), 64'(0));

`ifdef ADD8_SEQ_OVF_EN
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
`endif

        // random operations, some chained straight out of DONE
        for (int k = 0; k < 40; k++) begin
            if (k % 5 == 0) begin
                issue($urandom, $urandom, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b1);
                wait_done(cyc, bc);
                check("rand_chain_latency", 64'(cyc), 64'(N + 1));
            end else begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                run_op($urandom, $urandom, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
